// File: rtl/com_status_reg_gen.sv
// Parametrised sticky/level status register with overflow tracking, rising-edge
// capture, saturating event counter and a maskable registered interrupt.
module com_status_reg_gen #(
    parameter int N_STICKY = 14,
    parameter int N_LEVEL  = 6,
    parameter int STATUS_W = 32,
    parameter int CNT_W    = 16
) (
    input  logic                fw_axi_clk,
    input  logic                fw_rst,
    input  logic                clear_all,
    input  logic                clear_w1c,
    input  logic [N_STICKY-1:0] clear_mask,
    input  logic [N_STICKY-1:0] event_i,
    input  logic [N_LEVEL-1:0]  level_i,
    input  logic [N_STICKY-1:0] irq_mask,
    output logic [STATUS_W-1:0] status_o,
    output logic [N_STICKY-1:0] overflow_o,
    output logic [N_LEVEL-1:0]  rise_o,
    output logic [CNT_W-1:0]    event_cnt_o,
    output logic                irq_o
);

    localparam int PC_W  = $clog2(N_STICKY + 1);
    localparam int SUM_W = (CNT_W + 1 > PC_W + 1) ? CNT_W + 1 : PC_W + 1;

    generate
        if (N_STICKY < 1 || N_LEVEL < 1 || CNT_W < 4 ||
            N_STICKY + N_LEVEL > STATUS_W) begin : g_param_err
            $error("com_status_reg_gen: illegal parameter combination");
        end
    endgenerate

    function automatic logic [SUM_W-1:0] popcount(input logic [N_STICKY-1:0] v);
        logic [SUM_W-1:0] n;
        n = '0;
        for (int i = 0; i < N_STICKY; i++) begin
            n = n + SUM_W'(v[i]);
        end
        return n;
    endfunction

    // Adds at full width and clamps to the all-ones counter value.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [SUM_W-1:0] inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(cnt) + inc;
        if (sum > SUM_W'({CNT_W{1'b1}})) begin
            return {CNT_W{1'b1}};
        end
        return sum[CNT_W-1:0];
    endfunction

    logic [N_STICKY-1:0] sticky_p0;
    logic [N_STICKY-1:0] ovf_p0;
    logic [N_LEVEL-1:0]  level_p0;
    logic [N_LEVEL-1:0]  rise_p0;
    logic [CNT_W-1:0]    cnt_p0;
    logic                irq_p1;

    logic [N_STICKY-1:0] w1c;
    logic [N_STICKY-1:0] sticky_nxt;
    logic [N_STICKY-1:0] ovf_nxt;
    logic [N_LEVEL-1:0]  rise_nxt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                irq_nxt;

    always_comb begin
        w1c        = {N_STICKY{clear_w1c}} & clear_mask;
        sticky_nxt = event_i | (sticky_p0 & ~w1c);
        // A W1C in the same cycle acknowledges the old event, so no loss is flagged.
        ovf_nxt    = (event_i & sticky_p0 & ~w1c) | (ovf_p0 & ~w1c);
        rise_nxt   = rise_p0 | (level_i & ~level_p0);
        cnt_nxt    = sat_add(cnt_p0, popcount(event_i));
        irq_nxt    = (|(sticky_p0 & irq_mask)) | (|ovf_p0);
    end

    // Stage p0: capture events and levels
    always_ff @(posedge fw_axi_clk) begin
        if (fw_rst) begin
            sticky_p0 <= '0;
            ovf_p0    <= '0;
            level_p0  <= '0;
            rise_p0   <= '0;
            cnt_p0    <= '0;
        end else if (clear_all) begin
            sticky_p0 <= '0;
            ovf_p0    <= '0;
            level_p0  <= level_i;
            rise_p0   <= '0;
            cnt_p0    <= '0;
        end else begin
            sticky_p0 <= sticky_nxt;
            ovf_p0    <= ovf_nxt;
            level_p0  <= level_i;
            rise_p0   <= rise_nxt;
            cnt_p0    <= cnt_nxt;
        end
    end

    // Stage p1: interrupt from registered status
    always_ff @(posedge fw_axi_clk) begin
        if (fw_rst || clear_all) begin
            irq_p1 <= 1'b0;
        end else begin
            irq_p1 <= irq_nxt;
        end
    end

    always_comb begin
        status_o                     = '0;
        status_o[N_STICKY-1:0]       = sticky_p0;
        status_o[N_STICKY+:N_LEVEL]  = level_p0;
    end

    assign overflow_o  = ovf_p0;
    assign rise_o      = rise_p0;
    assign event_cnt_o = cnt_p0;
    assign irq_o       = irq_p1;

endmodule

// File: tb/tb_com_status_reg_gen.sv
// Bench for com_status_reg_gen: directed scenarios plus randomized traffic
// against an event-level reference model (default, CNT_W=4 and wide variants).
module tb_com_status_reg_gen;

    logic        fw_axi_clk = 1'b0;
    always #5 fw_axi_clk = ~fw_axi_clk;

    logic        fw_rst, clear_all, clear_w1c;
    logic [13:0] clear_mask, event_i, irq_mask;
    logic [5:0]  level_i;

    logic [31:0] status_o;
    logic [13:0] overflow_o;
    logic [5:0]  rise_o;
    logic [15:0] event_cnt_o;
    logic        irq_o;

    logic [31:0] status4;
    logic [13:0] ovf4;
    logic [5:0]  rise4;
    logic [3:0]  cnt4;
    logic        irq4;

    logic [19:0] ev_w, zero_w;
    logic [11:0] lvl_w;
    logic [31:0] status_w;
    logic [19:0] ovf_w;
    logic [11:0] rise_w;
    logic [15:0] cnt_w;
    logic        irq_w;

    com_status_reg_gen dut (
        .fw_axi_clk(fw_axi_clk), .fw_rst(fw_rst), .clear_all(clear_all),
        .clear_w1c(clear_w1c), .clear_mask(clear_mask), .event_i(event_i),
        .level_i(level_i), .irq_mask(irq_mask), .status_o(status_o),
        .overflow_o(overflow_o), .rise_o(rise_o), .event_cnt_o(event_cnt_o),
        .irq_o(irq_o)
    );

    com_status_reg_gen #(.CNT_W(4)) dut4 (
        .fw_axi_clk(fw_axi_clk), .fw_rst(fw_rst), .clear_all(clear_all),
        .clear_w1c(clear_w1c), .clear_mask(clear_mask), .event_i(event_i),
        .level_i(level_i), .irq_mask(irq_mask), .status_o(status4),
        .overflow_o(ovf4), .rise_o(rise4), .event_cnt_o(cnt4),
        .irq_o(irq4)
    );

    com_status_reg_gen #(.N_STICKY(20), .N_LEVEL(12), .STATUS_W(32)) dut_w (
        .fw_axi_clk(fw_axi_clk), .fw_rst(fw_rst), .clear_all(1'b0),
        .clear_w1c(1'b0), .clear_mask(zero_w), .event_i(ev_w),
        .level_i(lvl_w), .irq_mask(zero_w), .status_o(status_w),
        .overflow_o(ovf_w), .rise_o(rise_w), .event_cnt_o(cnt_w),
        .irq_o(irq_w)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference state: pending events, lost events, seen rises, last level, totals
    logic [13:0] m_sticky, m_ovf;
    logic [5:0]  m_rise, m_lvl;
    int          m_cnt, m_cnt4;
    logic        m_irq;

    task automatic model_step();
        int   n;
        logic want_irq;
        want_irq = 1'b0;
        for (int k = 0; k < 14; k++) begin
            if ((m_sticky[k] && irq_mask[k]) || m_ovf[k]) want_irq = 1'b1;
        end
        if (fw_rst) begin
            m_sticky = '0; m_ovf = '0; m_rise = '0; m_lvl = '0;
            m_cnt = 0; m_cnt4 = 0; m_irq = 1'b0;
        end else if (clear_all) begin
            m_sticky = '0; m_ovf = '0; m_rise = '0; m_lvl = level_i;
            m_cnt = 0; m_cnt4 = 0; m_irq = 1'b0;
        end else begin
            for (int k = 0; k < 14; k++) begin
                bit ack;
                ack = clear_w1c && clear_mask[k];
                if (event_i[k]) begin
                    if (ack) m_ovf[k] = 1'b0;
                    else if (m_sticky[k]) m_ovf[k] = 1'b1;
                    m_sticky[k] = 1'b1;
                end else if (ack) begin
                    m_sticky[k] = 1'b0;
                    m_ovf[k]    = 1'b0;
                end
            end
            for (int j = 0; j < 6; j++) begin
                if (level_i[j] && !m_lvl[j]) m_rise[j] = 1'b1;
            end
            m_lvl = level_i;
            n = m_cnt + $countones(event_i);
            m_cnt = (n > 65535) ? 65535 : n;
            n = m_cnt4 + $countones(event_i);
            m_cnt4 = (n > 15) ? 15 : n;
            m_irq = want_irq;
        end
    endtask

    task automatic check_all();
        logic [31:0] exp_status;
        exp_status = {12'h000, m_lvl, m_sticky};
        chk("status", {32'h0, status_o}, {32'h0, exp_status});
        chk("overflow", {50'h0, overflow_o}, {50'h0, m_ovf});
        chk("rise", {58'h0, rise_o}, {58'h0, m_rise});
        chk("event_cnt", {48'h0, event_cnt_o}, 64'(m_cnt));
        chk("irq", {63'h0, irq_o}, {63'h0, m_irq});
        chk("cnt4", {60'h0, cnt4}, 64'(m_cnt4));
    endtask

    task automatic cycle();
        @(posedge fw_axi_clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        fw_rst = 1'b1; clear_all = 1'b0; clear_w1c = 1'b0;
        clear_mask = '0; irq_mask = '0;
        event_i = 14'h3FFF; level_i = 6'h3F;
        ev_w = '0; lvl_w = '0; zero_w = '0;
        #2;

        // Reset with every input asserted
        repeat (3) cycle();
        fw_rst = 1'b0; event_i = '0;
        cycle();
        chk("t1_rise", {58'h0, rise_o}, 64'h3F);
        chk("t1_status", {32'h0, status_o}, 64'h000F_C000);
        chk("t1_cnt", {48'h0, event_cnt_o}, 64'd0);

        // Two events, masked irq, W1C of one bit; wide variant in parallel
        event_i = 14'h0005; irq_mask = 14'h0001;
        ev_w = 20'h80000; lvl_w = 12'h800;
        cycle();
        chk("t2_sticky", {50'h0, status_o[13:0]}, 64'h0005);
        chk("t2_cnt", {48'h0, event_cnt_o}, 64'd2);
        chk("t6_status", {32'h0, status_w}, 64'h8008_0000);
        event_i = '0; ev_w = '0;
        cycle();
        chk("t2_irq_set", {63'h0, irq_o}, 64'd1);
        clear_w1c = 1'b1; clear_mask = 14'h0001;
        cycle();
        chk("t2_w1c", {50'h0, status_o[13:0]}, 64'h0004);
        clear_w1c = 1'b0; clear_mask = '0;
        cycle();
        chk("t2_irq_clr", {63'h0, irq_o}, 64'd0);

        // Lost event on bit 3, then event with simultaneous W1C
        irq_mask = '0; clear_all = 1'b1;
        cycle();
        clear_all = 1'b0; event_i = 14'h0008;
        cycle();
        event_i = '0;
        cycle();
        event_i = 14'h0008;
        cycle();
        event_i = '0;
        chk("t3_ovf", {50'h0, overflow_o}, 64'h0008);
        chk("t3_cnt", {48'h0, event_cnt_o}, 64'd2);
        cycle();
        chk("t3_irq", {63'h0, irq_o}, 64'd1);
        event_i = 14'h0008; clear_w1c = 1'b1; clear_mask = 14'h0008;
        cycle();
        chk("t3_sticky", {63'h0, status_o[3]}, 64'd1);
        event_i = '0; clear_w1c = 1'b0; clear_mask = '0;
        cycle();

        // clear_all beats a full event burst; held level gives no rise
        event_i = 14'h3FFF; clear_all = 1'b1;
        cycle();
        chk("t4_status", {32'h0, status_o}, 64'h000F_C000);
        chk("t4_ovf", {50'h0, overflow_o}, 64'd0);
        chk("t4_rise", {58'h0, rise_o}, 64'd0);
        chk("t4_cnt", {48'h0, event_cnt_o}, 64'd0);
        clear_all = 1'b0;
        cycle();
        chk("t4_no_rise", {58'h0, rise_o}, 64'd0);
        chk("t5_cnt14", {60'h0, cnt4}, 64'd14);
        cycle();
        chk("t5_cnt15", {60'h0, cnt4}, 64'd15);
        cycle();
        chk("t5_hold", {60'h0, cnt4}, 64'd15);
        event_i = '0; clear_all = 1'b1;
        cycle();
        chk("t5_clear", {60'h0, cnt4}, 64'd0);
        clear_all = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            event_i    = ($urandom_range(0, 2) == 0) ? 14'($urandom) : 14'h0;
            clear_w1c  = ($urandom_range(0, 5) == 0);
            clear_mask = 14'($urandom);
            clear_all  = ($urandom_range(0, 40) == 0);
            fw_rst     = ($urandom_range(0, 150) == 0);
            irq_mask   = ($urandom_range(0, 7) == 0) ? 14'($urandom) : irq_mask;
            if ($urandom_range(0, 3) == 0) level_i = 6'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
